// File: rtl/ip_daec_8lc_store_buffer.sv
// Store buffer behind the IP-DAEC 8LC encoder: packs IP_word, IP bit and codeword
// into 72-bit storage words, queues them in a small FIFO and drains them to memory.
module ip_daec_8lc_store_buffer #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [21:0]              in_ip_word,
   input  logic                     in_ip,
   input  logic [48:0]              in_codeword,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [71:0]              out_word,
   input  logic                     flush,
   input  logic                     clr_err,
   output logic                     ip_err,
   output logic [$clog2(DEPTH):0]   level,
   output logic [CNT_W-1:0]         wr_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [71:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          push;
   logic          pop;
   logic          ip_bad;

   // Both handshakes depend only on registered state and flush, never on the
   // opposite port, so a full buffer refuses a push even while it is being popped.
   assign in_ready  = (level != LW'(DEPTH)) && !flush;
   assign out_valid = (level != '0) && !flush;
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;
   assign out_word  = mem[rd_ptr];
   assign ip_bad    = (^in_ip_word) != in_ip;

   // NOTE: storage is reset so out_word reads zero out of reset; flush only
   // rewinds the pointers and leaves stale entries in place.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (push) begin
         mem[wr_ptr] <= {in_ip_word, in_ip, in_codeword};
      end
   end

   // NOTE: all state uses non-blocking assignments so every register samples
   // the pre-edge values of its neighbours.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ip_err   <= 1'b0;
         wr_count <= '0;
      end else begin
         // A fresh mismatch takes priority over a simultaneous clear.
         if (push && ip_bad) ip_err <= 1'b1;
         else if (clr_err)   ip_err <= 1'b0;
         if (pop && (wr_count != '1)) wr_count <= wr_count + 1'b1;
      end
   end

endmodule
